dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Memory-side (responder) end of the datapath's mem_bus_if, extended with a valid/ready handshake.
//  Serves one word-addressed load/store at a time after a fixed, configurable latency, so the
//  datapath/controller can be exercised against non-ideal (multi-cycle) data memory.
//  Sits between the datapath's dmem_bus and a byte-enabled word RAM.
// PARAMETERS
//  DATA_W   32  data width; fixed at 32 (4 byte lanes)
//  DEPTH    64  number of words in backing RAM; word index = req_addr[AW+1:2], AW=$clog2(DEPTH)
//  LATENCY  2   cycles from request acceptance to rsp_valid; legal range 1..15
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   synchronous, active-low reset
//  req_valid  in   1   initiator presents a request
//  req_ready  out  1   responder can accept (IDLE only)
//  req_addr   in   32  byte address
//  req_we     in   1   1 = store, 0 = load
//  req_be     in   4   byte enables for stores (bit i -> wdata[8i+7:8i]); ignored for loads
//  req_wdata  in   32  store data
//  rsp_valid  out  1   response held until accepted
//  rsp_ready  in   1   initiator accepts response
//  rsp_rdata  out  32  load data (0 for stores and errors)
//  rsp_err    out  1   misaligned (addr[1:0]!=0) or out-of-range (word index >= DEPTH)
// BEHAVIOUR
//  - One clock; synchronous active-low reset. While rst_n=0: state IDLE, req_ready=0, rsp_valid=0,
//    rsp_rdata=0, rsp_err=0, counter=0. req_ready=1 from the first cycle after rst_n rises.
//  - RAM contents are NOT reset; reset mid-operation aborts the pending request, no RAM write.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: req_ready=1. On req_valid: latch addr/we/be/wdata, cnt=LATENCY-1; go WAIT (or RESP
//          directly with commit if LATENCY==1).
//    WAIT: req_ready=0; cnt decrements each cycle; when cnt==1 commit and enter RESP next edge.
//    RESP: rsp_valid=1, outputs stable until rsp_valid&&rsp_ready; then IDLE (req_ready=1 next cycle).
//  - Commit (single edge): error check; store -> write enabled lanes only; load -> rsp_rdata=RAM word
//    (full word, be ignored). Error -> no write, rsp_rdata=0, rsp_err=1.
//  - Latency: acceptance at edge T -> rsp_valid high in the cycle after edge T+LATENCY-1.
//    Back-to-back throughput: one request per LATENCY+1 cycles with rsp_ready held high.
//  - Single outstanding request; req_* ignored outside IDLE. No combinational path from any
//    input to req_ready or rsp_*.
//  - Read-after-write to same address in consecutive transactions returns the new data.
// STRUCTURE
//  - mem_pkg: typedef enum logic[1:0] {IDLE, WAIT, RESP} dmem_state_t; localparam BYTES=4;
//    localparam LAT_W=4.
//  - Sub-module ram_be_sp (single-port word RAM, per-byte write enable, synchronous write,
//    asynchronous read); FSM, counter and error check live in dmem_responder.
// TESTING
//  1. Reset: hold rst_n=0 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0 throughout; no write.
//  2. Store 0xDEADBEEF @0x10 be=4'hF, then load @0x10 (LATENCY=2) -> rsp_valid 2 cycles after
//     each accept, rdata=0xDEADBEEF, rsp_err=0.
//  3. Partial store 0x000000AA be=4'b0001 @0x10 over 0xDEADBEEF -> load returns 0xDEADBEAA.
//  4. Misaligned load @0x12 and load @(DEPTH*4) -> rsp_err=1, rdata=0; RAM unchanged.
//  5. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata/err stable, req_ready=0;
//     release -> IDLE next cycle.
//  6. Reset asserted in WAIT of a store 0x12345678 @0x20 -> after reset, load @0x20 returns the
//     prior contents (store dropped); repeat with LATENCY=1 and LATENCY=15 for counter edges.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder and its backing RAM.
// Includes the address legality check used at commit time.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int BYTES = 4;
  localparam int LAT_W = 4;

  // A request is illegal if it is not word aligned or its word index falls past the RAM.
  function automatic logic addr_error(input logic [31:0] addr, input int depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= 32'(depth));
  endfunction

endpackage

// File: rtl/ram_be_sp.sv
// Single-port word RAM with per-byte write enables.
// Writes land on the rising edge; the read port is combinational.
module ram_be_sp
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BYTES-1:0]  be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would need a write port per word
  // and contents are expected to survive a controller reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the datapath bus: accepts one load/store at a time and answers
// after a fixed latency through a valid/ready response channel.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [BYTES-1:0]  req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(LATENCY - 1);
  localparam bit                DIRECT   = (LATENCY == 1);

  dmem_state_t       state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              accept, commit;

  logic [31:0]       addr_q;
  logic              we_q;
  logic [BYTES-1:0]  be_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req_ready_q, rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [31:0]       c_addr;
  logic              c_we, c_err, ram_we;
  logic [BYTES-1:0]  c_be;
  logic [DATA_W-1:0] c_wdata, ram_rdata;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          accept = 1'b1;
          cnt_d  = LAT_INIT;
          if (DIRECT) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With a one-cycle latency the commit happens on the accepting edge, so it must
  // see the live request rather than the not-yet-loaded capture registers.
  always_comb begin
    c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    c_we    = (state_q == IDLE) ? req_we    : we_q;
    c_be    = (state_q == IDLE) ? req_be    : be_q;
    c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    c_err   = addr_error(c_addr, DEPTH);
    ram_we  = commit && c_we && !c_err && rst_n;
  end

  ram_be_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (c_be),
    .addr  (c_addr[AW+1:2]),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      if (commit) begin
        rsp_err_q   <= c_err;
        rsp_rdata_q <= (c_we || c_err) ? '0 : ram_rdata;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end
    end
  end

  // Request capture is only ever read after an accept, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      be_q    <= req_be;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
